// File: rtl/motor_pwm_driver_pkg.sv
// ============================================================================
// Module : motor_pkg
// Brief  : Shared constants, run/stop state type, clamp and soft-start helpers
//          for the motor PWM driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package motor_pkg;

    localparam logic [3:0] SPEED_MAX        = 4'd15;
    localparam int         TICKS_PER_PERIOD = 15;

    // Soft-start caps for ramp 0..3, packed lowest entry first
    localparam logic [15:0] SOFT_CAP_TABLE = {4'd15, 4'd12, 4'd8, 4'd4};

    typedef enum logic [0:0] {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [3:0] clamp4(input logic signed [5:0] v);
        if (v < 0)
            return 4'd0;
        else if (v > $signed({2'b00, SPEED_MAX}))
            return SPEED_MAX;
        else
            return v[3:0];
    endfunction

    function automatic logic [3:0] soft_cap(input logic [1:0] ramp);
        return SOFT_CAP_TABLE[{ramp, 2'b00} +: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/motor_pwm_driver_if.sv
// ============================================================================
// Module : motor_pwm_driver_if
// Brief  : Command inputs and PWM/status outputs of the motor PWM driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface motor_pwm_driver_if;

    logic [3:0] speed_i;
    logic [3:0] dir_i;
    logic       pwm_l;
    logic       pwm_r;
    logic [3:0] duty_l;
    logic [3:0] duty_r;
    logic       period_tick;
    logic       running;

    modport master (
        output speed_i, dir_i,
        input  pwm_l, pwm_r, duty_l, duty_r, period_tick, running
    );

    modport slave (
        input  speed_i, dir_i,
        output pwm_l, pwm_r, duty_l, duty_r, period_tick, running
    );

endinterface

`default_nettype wire

// File: rtl/motor_pwm_driver_timebase.sv
// ============================================================================
// Module : pwm_timebase
// Brief  : Prescaler plus 0..14 tick counter; flags the last clk of a period.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_timebase
    import motor_pkg::*;
#(
    parameter int PRESCALE = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic      [3:0] o_tick_cnt,
    output logic            o_period_end
);

    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]   c_presc_last = PW'(PRESCALE - 1);
    localparam logic [3:0]      c_tick_last  = 4'(TICKS_PER_PERIOD - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_tick;
    logic          w_presc_wrap;
    logic          w_tick_last;

    assign w_presc_wrap = (r_presc == c_presc_last);
    assign w_tick_last  = (r_tick == c_tick_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_tick  <= w_tick_last ? 4'd0 : r_tick + 4'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign o_tick_cnt   = r_tick;
    assign o_period_end = w_presc_wrap && w_tick_last;

endmodule

`default_nettype wire

// File: rtl/motor_pwm_driver.sv
// ============================================================================
// Module : motor_pwm_driver
// Brief  : Differential-steering PWM for left/right motors, duties sampled at
//          period boundaries. Optional soft-start ramp via SOFT_START_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int PRESCALE    = 64,
    parameter int DIR_CENTER  = 8,
    parameter int STEER_SHIFT = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    motor_pwm_driver_if.slave  bus
);

    localparam logic signed [5:0] c_dir_center = 6'(DIR_CENTER);

    logic [3:0]        w_tick_cnt;
    logic              w_period_end;
    logic signed [5:0] w_dir_s;
    logic signed [5:0] w_spd_s;
    logic signed [5:0] w_diff;
    logic signed [5:0] w_steer;
    logic signed [5:0] w_mix_l;
    logic signed [5:0] w_mix_r;
    logic [3:0]        w_clamp_l;
    logic [3:0]        w_clamp_r;
    logic [3:0]        w_load_l;
    logic [3:0]        w_load_r;
    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_duty_l;
    logic [3:0]        r_duty_r;
    logic              r_pwm_l;
    logic              r_pwm_r;
    logic              r_period_tick;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .o_tick_cnt   (w_tick_cnt),
        .o_period_end (w_period_end)
    );

    assign w_dir_s = $signed({2'b00, bus.dir_i});
    assign w_spd_s = $signed({2'b00, bus.speed_i});
    assign w_diff  = w_dir_s - c_dir_center;
    assign w_steer = w_diff >>> STEER_SHIFT;
    assign w_mix_l = w_spd_s + w_steer;
    assign w_mix_r = w_spd_s - w_steer;

    // Zero speed parks both wheels rather than pivoting in place
    assign w_clamp_l = (bus.speed_i == 4'd0) ? 4'd0 : clamp4(w_mix_l);
    assign w_clamp_r = (bus.speed_i == 4'd0) ? 4'd0 : clamp4(w_mix_r);

`ifdef SOFT_START_EN
    logic [1:0] r_ramp;
    logic [1:0] w_ramp_idx;
    logic [3:0] w_cap;

    // The load at STOP->RUN uses cap 0; each later load uses the advanced ramp
    assign w_ramp_idx = (r_state == STOP) ? 2'd0 :
                        (r_ramp == 2'd3)  ? 2'd3 : r_ramp + 2'd1;
    assign w_cap      = soft_cap(w_ramp_idx);
    assign w_load_l   = (w_clamp_l < w_cap) ? w_clamp_l : w_cap;
    assign w_load_r   = (w_clamp_r < w_cap) ? w_clamp_r : w_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ramp <= 2'd0;
        else if (w_period_end)
            r_ramp <= w_ramp_idx;
    end
`else
    assign w_load_l = w_clamp_l;
    assign w_load_r = w_clamp_r;
`endif

    always_comb begin
        w_state_next = r_state;
        if (w_period_end) begin
            case (r_state)
                STOP:    if ((w_load_l != 4'd0) || (w_load_r != 4'd0)) w_state_next = RUN;
                RUN:     if ((w_load_l == 4'd0) && (w_load_r == 4'd0)) w_state_next = STOP;
                default: w_state_next = STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= STOP;
            r_duty_l      <= 4'd0;
            r_duty_r      <= 4'd0;
            r_pwm_l       <= 1'b0;
            r_pwm_r       <= 1'b0;
            r_period_tick <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_period_tick <= w_period_end;
            r_pwm_l       <= (r_state == RUN) && (w_tick_cnt < r_duty_l);
            r_pwm_r       <= (r_state == RUN) && (w_tick_cnt < r_duty_r);
            if (w_period_end) begin
                r_duty_l <= w_load_l;
                r_duty_r <= w_load_r;
            end
        end
    end

    assign bus.pwm_l       = r_pwm_l;
    assign bus.pwm_r       = r_pwm_r;
    assign bus.duty_l      = r_duty_l;
    assign bus.duty_r      = r_duty_r;
    assign bus.period_tick = r_period_tick;
    assign bus.running     = (r_state == RUN);

endmodule

`default_nettype wire
